// File: rtl/pulse_gen_prog.sv
// Programmable period/width pulse generator (periodic or one-shot); optional event counter under PULSE_GEN_PROG_PULSE_CNT_EN.
// Latency: pulse rises on the edge that ends period_q enabled cycles counted from counter=0; outputs are registered.
// Backpressure: none; en pauses counting, load/start take priority over a coincident terminal count.
module pulse_gen_prog #(
    parameter int WIDTH          = 27,
    parameter int DEFAULT_PERIOD = 100000000,
    parameter int PULSE_W        = 1,
    parameter int CNT_W          = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             start,
    input  logic             load,
    input  logic [WIDTH-1:0] period_in,
    input  logic             oneshot,
    output logic             pulse,
`ifdef PULSE_GEN_PROG_PULSE_CNT_EN
    output logic [CNT_W-1:0] pulse_cnt,
`endif
    output logic             busy
);

    localparam logic [WIDTH-1:0] DEF_RAW = WIDTH'(DEFAULT_PERIOD);
    localparam logic [WIDTH-1:0] DEF_P   = (DEF_RAW < WIDTH'(2)) ? WIDTH'(2) : DEF_RAW;
    localparam logic [31:0]      PW32    = PULSE_W;

    function automatic logic [WIDTH-1:0] clamp_period(input logic [WIDTH-1:0] p);
        return (p < WIDTH'(2)) ? WIDTH'(2) : p;
    endfunction

    logic [WIDTH-1:0] counter;
    logic [WIDTH-1:0] period_q;
    logic [WIDTH-1:0] wcnt;
    logic [WIDTH-1:0] wcnt_nxt;
    logic [WIDTH-1:0] eff_w;
    logic             armed;
    logic             fire;

    // Width is capped at period_q-1 so the pulse always drops before the next event.
    always_comb begin
        eff_w = PW32[WIDTH-1:0];
        if (PW32 >= 32'(period_q)) begin
            eff_w = period_q - 1'b1;
        end
    end

    assign fire = armed & en & (counter == period_q - 1'b1) & ~load & ~start;

    always_comb begin
        wcnt_nxt = '0;
        if (fire) begin
            wcnt_nxt = eff_w;
        end else if (wcnt != '0) begin
            wcnt_nxt = wcnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            counter  <= '0;
            period_q <= DEF_P;
            wcnt     <= '0;
            armed    <= 1'b1;
            pulse    <= 1'b0;
        end else begin
            if (load) begin
                period_q <= clamp_period(period_in);
            end
            if (load || start || fire) begin
                counter <= '0;
            end else if (armed && en) begin
                counter <= counter + 1'b1;
            end
            if (start) begin
                armed <= 1'b1;
            end else if (fire && oneshot) begin
                armed <= 1'b0;
            end
            wcnt  <= wcnt_nxt;
            pulse <= (wcnt_nxt != '0);
        end
    end

    assign busy = armed;

`ifdef PULSE_GEN_PROG_PULSE_CNT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pulse_cnt <= '0;
        end else if (fire) begin
            pulse_cnt <= pulse_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pulse_gen_prog.sv
// Directed bench for pulse_gen_prog: WIDTH=8, DEFAULT_PERIOD=10, one instance with PULSE_W=1 and one with PULSE_W=3.
module tb_pulse_gen_prog;

    logic       clk;
    logic       reset;
    logic       en;
    logic       start;
    logic       load;
    logic       oneshot;
    logic [7:0] period_in;
    logic       pulse1, busy1, pulse3, busy3;
`ifdef PULSE_GEN_PROG_PULSE_CNT_EN
    logic [3:0] pcnt1, pcnt3;
`endif

    int errors = 0;
    int checks = 0;

    pulse_gen_prog #(.WIDTH(8), .DEFAULT_PERIOD(10), .PULSE_W(1), .CNT_W(4)) u1 (
        .clk(clk), .reset(reset), .en(en), .start(start), .load(load),
        .period_in(period_in), .oneshot(oneshot), .pulse(pulse1),
`ifdef PULSE_GEN_PROG_PULSE_CNT_EN
        .pulse_cnt(pcnt1),
`endif
        .busy(busy1)
    );

    pulse_gen_prog #(.WIDTH(8), .DEFAULT_PERIOD(10), .PULSE_W(3), .CNT_W(4)) u3 (
        .clk(clk), .reset(reset), .en(en), .start(start), .load(load),
        .period_in(period_in), .oneshot(oneshot), .pulse(pulse3),
`ifdef PULSE_GEN_PROG_PULSE_CNT_EN
        .pulse_cnt(pcnt3),
`endif
        .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Expected pulse: high for w edges starting at edge 'first', repeating every 'per' (0 = once).
    // Expected busy (instance u1 only): 1 while edge index < drop.
    task automatic run_chk(input int inst, input string tag, input int n, input int first,
                           input int per, input int w, input int drop);
        int  k;
        logic ep;
        for (int i = 1; i <= n; i++) begin
            tick();
            k  = i - first;
            ep = (k >= 0) && ((per == 0) ? (k < w) : ((k % per) < w));
            if (inst == 0) begin
                chk($sformatf("%s_pulse@%0d", tag, i), {31'd0, pulse1}, {31'd0, ep});
                chk($sformatf("%s_busy@%0d", tag, i), {31'd0, busy1}, (i < drop) ? 32'd1 : 32'd0);
            end else begin
                chk($sformatf("%s_pulse3@%0d", tag, i), {31'd0, pulse3}, {31'd0, ep});
            end
        end
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; start = 1'b0; load = 1'b0; oneshot = 1'b0; period_in = 8'd0;
        #2 reset = 1'b0;
        #1;
        chk("rst_pulse", {31'd0, pulse1}, 32'd0);
        chk("rst_busy", {31'd0, busy1}, 32'd1);
        repeat (2) tick();
        reset = 1'b1;
        en    = 1'b1;

        // Default period 10: pulses on edges 10, 20, 30.
        run_chk(0, "per10", 30, 10, 10, 1, 1000);

        // load 4 mid-count: no pulse on the load edge, then every 4.
        run_chk(0, "mid", 3, 1000, 0, 1, 1000);
        load = 1'b1; period_in = 8'd4;
        tick();
        load = 1'b0;
        chk("ld4_edge", {31'd0, pulse1}, 32'd0);
        run_chk(0, "ld4", 12, 4, 4, 1, 1000);

        // load 0 clamps to 2.
        load = 1'b1; period_in = 8'd0;
        tick();
        load = 1'b0;
        chk("ld0_edge", {31'd0, pulse1}, 32'd0);
        run_chk(0, "ld0", 8, 2, 2, 1, 1000);

        // Pause: 6 enabled, 5 paused, pulse on the 4th enabled edge after resume.
        load = 1'b1; period_in = 8'd10;
        tick();
        load = 1'b0;
        run_chk(0, "pre_pause", 6, 1000, 0, 1, 1000);
        en = 1'b0;
        run_chk(0, "pause", 5, 1000, 0, 1, 1000);
        en = 1'b1;
        run_chk(0, "post_pause", 10, 4, 10, 1, 1000);

        // One-shot.
        load = 1'b1; period_in = 8'd10; oneshot = 1'b1;
        tick();
        load = 1'b0;
        run_chk(0, "os", 10, 10, 0, 1, 10);
        run_chk(0, "os_idle", 50, 1000, 0, 1, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", {31'd0, busy1}, 32'd1);
        chk("start_pulse", {31'd0, pulse1}, 32'd0);
        run_chk(0, "os2", 10, 10, 0, 1, 10);
        run_chk(0, "os2_tail", 3, 1000, 0, 1, 0);

        // load+start together, then PULSE_W=3 at period 4: high 3, low 1.
        oneshot = 1'b0; start = 1'b1; load = 1'b1; period_in = 8'd4;
        tick();
        start = 1'b0; load = 1'b0;
        chk("ls_busy", {31'd0, busy1}, 32'd1);
        chk("ls_pulse3", {31'd0, pulse3}, 32'd0);
        run_chk(1, "pw3", 12, 4, 4, 3, 1000);

        // load+start on the terminal-count cycle suppresses the event.
        run_chk(0, "pre_tc", 3, 1000, 0, 1, 1000);
        start = 1'b1; load = 1'b1; period_in = 8'd4;
        tick();
        start = 1'b0; load = 1'b0;
        chk("tc_pulse", {31'd0, pulse1}, 32'd0);
        chk("tc_pulse3", {31'd0, pulse3}, 32'd0);
        chk("tc_busy", {31'd0, busy1}, 32'd1);
        run_chk(0, "after_tc", 4, 4, 4, 1, 1000);

        // Async reset mid-pulse: outputs clear without a clock edge, period returns to 10.
        load = 1'b1; period_in = 8'd6;
        tick();
        load = 1'b0;
        chk("ld6_edge", {31'd0, pulse1}, 32'd0);
        run_chk(0, "pre_rst", 6, 6, 6, 1, 1000);
        reset = 1'b0;
        #2;
        chk("arst_pulse", {31'd0, pulse1}, 32'd0);
        chk("arst_pulse3", {31'd0, pulse3}, 32'd0);
        chk("arst_busy", {31'd0, busy1}, 32'd1);
`ifdef PULSE_GEN_PROG_PULSE_CNT_EN
        chk("arst_cnt", {28'd0, pcnt1}, 32'd0);
`endif
        tick();
        reset = 1'b1;
        run_chk(0, "rst_per10", 20, 10, 10, 1, 1000);
`ifdef PULSE_GEN_PROG_PULSE_CNT_EN
        chk("cnt_2", {28'd0, pcnt1}, 32'd2);
`endif

        // 15 more events: 17 total, a 4-bit count wraps to 1; start keeps it.
        run_chk(0, "long", 150, 10, 10, 1, 1000);
`ifdef PULSE_GEN_PROG_PULSE_CNT_EN
        chk("cnt_wrap", {28'd0, pcnt1}, 32'd1);
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
`ifdef PULSE_GEN_PROG_PULSE_CNT_EN
        chk("cnt_after_start", {28'd0, pcnt1}, 32'd1);
`endif

        // Period 2 caps the 3-cycle width to 1 on u3.
        load = 1'b1; period_in = 8'd2;
        tick();
        load = 1'b0;
        run_chk(1, "pw_clamp", 8, 2, 2, 1, 1000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_gen_prog.md
Name: pulse_gen_prog

Overview:
- Programmable-period, programmable-width pulse generator; next generation of the fixed 1 Hz pulse block.
- Period is runtime-loadable, with free-running (periodic) and one-shot modes, a level enable and a restart strobe.
- Drives display/counter update strobes (e.g. Gray counter stepping) from the 100 MHz board clock.

Parameters:
- WIDTH, 27, width of period register and internal counter
- DEFAULT_PERIOD, 100000000, period loaded at reset, in clk cycles (1 s at 10 ns)
- PULSE_W, 1, pulse high time in clk cycles (>=1)
- CNT_W, 16, width of pulse_cnt (only used with PULSE_CNT_EN)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- en  in  1  level enable; counter advances only while high
- start  in  1  one-cycle strobe: counter<=0, arm generator
- load  in  1  one-cycle strobe: period_q<=period_in, counter<=0
- period_in  in  WIDTH  new period in cycles
- oneshot  in  1  0 = periodic, 1 = single pulse per start
- pulse  out  1  registered output pulse
- busy  out  1  generator armed and counting
- pulse_cnt  out  CNT_W  pulse event count (PULSE_CNT_EN only)

Behaviour:
- Reset (reset=0, async):
  - counter=0, period_q=DEFAULT_PERIOD (clamped as below), width counter=0.
  - pulse=0, busy=1 (armed), pulse_cnt=0.
- Period clamp: any period value <2, whether from reset default or load, is stored as 2.
- Counting:
  - Counting happens only when armed=1 and en=1; each such edge counter<=counter+1.
  - When counter==period_q-1, the next edge sets counter<=0 and fires a pulse event.
- Period: first pulse event is registered exactly period_q enabled cycles after counter=0; subsequent events every period_q enabled cycles.
- Pulse width:
  - A pulse event loads the width counter with PULSE_W; pulse=1 while the width counter is nonzero.
  - Effective width is min(PULSE_W, period_q-1) so pulse always drops between events.
  - pulse continues to time out while en=0.
- en=0: counter holds its value (pause, not clear); no new events.
- oneshot=1: a pulse event clears armed (busy<=0) and counter<=0. No further events until start.
- oneshot=0: armed stays 1 forever after reset/start.
- start: counter<=0, armed<=1. An in-progress pulse is not truncated.
- load: period_q<=clamp(period_in), counter<=0. Armed state is unchanged.
- Priority in one cycle: load and start together means both apply (new period, counter 0, armed). load/start beat a coincident terminal count, so no pulse event fires that cycle.
- oneshot may change at any time. It is sampled at the pulse event.
- No combinational path from inputs to outputs.

Optional Feature:
- Macro: PULSE_GEN_PROG_PULSE_CNT_EN.
- Defined:
  - pulse_cnt port exists; increments by 1 on each pulse event and wraps 2^CNT_W-1 -> 0.
  - Cleared only by reset.
- Undefined: pulse_cnt port and its logic absent. All other behaviour is identical.

Test Plan:
- Test config: WIDTH=8, DEFAULT_PERIOD=10, PULSE_W=1, CNT_W=4.
- Reset release, en=1, oneshot=0 -> pulse high 1 cycle on the 10th, 20th, 30th edges after release; busy=1 throughout.
- load with period_in=4 mid-count -> counter restarts; pulses 4 edges after load, then every 4; no pulse from the old count. load with period_in=0 -> period 2, pulse every 2nd cycle.
- Pause: en=1 for 6 cycles, en=0 for 5, en=1 -> first pulse at 10th enabled cycle (15th overall); the counter value is retained across the pause.
- oneshot=1 -> single pulse at cycle 10, busy falls with it, no pulse for 50 further cycles; start -> busy=1, next pulse 10 cycles later. PULSE_W=3, period 4 -> pulse high 3 cycles, low 1.
- Async reset asserted mid-pulse and mid-count -> pulse=0, busy=1, period back to 10 immediately, without waiting for a clk edge. load+start on the terminal-count cycle -> no pulse that cycle.
- With PULSE_GEN_PROG_PULSE_CNT_EN: 17 pulses -> pulse_cnt reads 1 after wrap, and start does not clear it. Without the macro -> the build has no pulse_cnt port.
